// File: rtl/md_sched_pkg.sv
// Shared opcodes, latency defaults and decode helpers for the E-stage mul/div scheduler.
// MD_MAC_EN adds the madd/maddu/msub/msubu start codes.
package md_sched_pkg;

   localparam int MULT_LAT_DEF = 5;
   localparam int DIV_LAT_DEF  = 10;

   localparam logic [3:0] HILO_NONE  = 4'd0;
   localparam logic [3:0] HILO_MULT  = 4'd1;
   localparam logic [3:0] HILO_MULTU = 4'd2;
   localparam logic [3:0] HILO_DIV   = 4'd3;
   localparam logic [3:0] HILO_DIVU  = 4'd4;
   localparam logic [3:0] HILO_MTHI  = 4'd5;
   localparam logic [3:0] HILO_MTLO  = 4'd6;
   localparam logic [3:0] HILO_MFHI  = 4'd7;
   localparam logic [3:0] HILO_MFLO  = 4'd8;
   localparam logic [3:0] HILO_MADD  = 4'd9;
   localparam logic [3:0] HILO_MADDU = 4'd10;
   localparam logic [3:0] HILO_MSUB  = 4'd11;
   localparam logic [3:0] HILO_MSUBU = 4'd12;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_t;

   function automatic logic is_start(input logic [3:0] op);
      logic s;
      s = 1'b0;
      case (op)
         HILO_MULT, HILO_MULTU, HILO_DIV, HILO_DIVU: s = 1'b1;
`ifdef MD_MAC_EN
         HILO_MADD, HILO_MADDU, HILO_MSUB, HILO_MSUBU: s = 1'b1;
`endif
         default: s = 1'b0;
      endcase
      return s;
   endfunction

   function automatic logic is_div(input logic [3:0] op);
      return (op == HILO_DIV) || (op == HILO_DIVU);
   endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational mul/div/mac datapath producing the full {hi,lo} result and a divide-by-zero flag.
// Zero latency; no flow control. MD_MAC_EN adds accumulate/subtract against the current {hi,lo}.
module md_arith
   import md_sched_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic [63:0] hilo_cur,
   output logic [63:0] res,
   output logic        div0
);

   logic signed [63:0] prod_s;
   logic        [63:0] prod_u;
   logic        [31:0] dvs;
   logic        [31:0] quo_u, rem_u;
   logic signed [31:0] quo_s, rem_s;

   assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
   assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

   // A zero divisor is swapped for 1 so the dividers never see X; div0 masks the result.
   assign div0  = is_div(op) && (rt_val == 32'd0);
   assign dvs   = (rt_val == 32'd0) ? 32'd1 : rt_val;
   assign quo_u = rs_val / dvs;
   assign rem_u = rs_val % dvs;
   assign quo_s = $signed(rs_val) / $signed(dvs);
   assign rem_s = $signed(rs_val) % $signed(dvs);

   always_comb begin
      res = 64'd0;
      case (op)
         HILO_MULT:  res = prod_s;
         HILO_MULTU: res = prod_u;
         HILO_DIV:   res = div0 ? hilo_cur : {rem_s, quo_s};
         HILO_DIVU:  res = div0 ? hilo_cur : {rem_u, quo_u};
`ifdef MD_MAC_EN
         HILO_MADD:  res = hilo_cur + prod_s;
         HILO_MADDU: res = hilo_cur + prod_u;
         HILO_MSUB:  res = hilo_cur - prod_s;
         HILO_MSUBU: res = hilo_cur - prod_u;
`endif
         default:    res = hilo_cur;
      endcase
   end

endmodule

// File: rtl/md_sched.sv
// E-stage mul/div scheduler and HI/LO owner; optional MAC ops under MD_MAC_EN.
// Latency MULT_LAT/DIV_LAT busy cycles; codes arriving while busy or with req are dropped.
module md_sched
   import md_sched_pkg::*;
#(
   parameter int MULT_LAT = MULT_LAT_DEF,
   parameter int DIV_LAT  = DIV_LAT_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  hilo_type,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        req,
   output logic        busy,
   output logic [31:0] hilo_rd,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   md_state_t   state, state_nxt;
   logic [4:0]  count;
   logic [31:0] pend_hi, pend_lo;
   logic        pend_div0;
   logic [63:0] arith_res;
   logic        arith_div0;
   logic        start;
   logic        idle_wr;

   md_arith u_arith (
      .op       (hilo_type),
      .rs_val   (rs_val),
      .rt_val   (rt_val),
      .hilo_cur ({hi, lo}),
      .res      (arith_res),
      .div0     (arith_div0)
   );

   assign idle_wr = (state == ST_IDLE) && !req;
   assign start   = idle_wr && is_start(hilo_type);
   assign busy    = (state == ST_RUN);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start) state_nxt = ST_RUN;
         ST_RUN:  if (count == 5'd1) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count     <= 5'd0;
         pend_hi   <= 32'd0;
         pend_lo   <= 32'd0;
         pend_div0 <= 1'b0;
         hi        <= 32'd0;
         lo        <= 32'd0;
      end else if (start) begin
         pend_hi   <= arith_res[63:32];
         pend_lo   <= arith_res[31:0];
         pend_div0 <= arith_div0;
         count     <= is_div(hilo_type) ? 5'(DIV_LAT) : 5'(MULT_LAT);
      end else if (state == ST_RUN) begin
         count <= count - 5'd1;
         // Divide by zero still burns the full latency but leaves HI/LO untouched.
         if (count == 5'd1 && !pend_div0) begin
            hi <= pend_hi;
            lo <= pend_lo;
         end
      end else if (idle_wr) begin
         if (hilo_type == HILO_MTHI) hi <= rs_val;
         if (hilo_type == HILO_MTLO) lo <= rs_val;
      end
   end

   always_comb begin
      hilo_rd = 32'd0;
      if (hilo_type == HILO_MFHI) hilo_rd = hi;
      if (hilo_type == HILO_MFLO) hilo_rd = lo;
   end

endmodule

// File: tb/tb_md_sched.sv
// Directed-vector bench for md_sched; define MD_MAC_EN to also cover the MAC ops.
module tb_md_sched;
   import md_sched_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  hilo_type;
   logic [31:0] rs_val, rt_val;
   logic        req;
   logic        busy;
   logic [31:0] hilo_rd, hi, lo;

   int nvec = 0;
   int nerr = 0;
   int n;

   md_sched #(.MULT_LAT(5), .DIV_LAT(10)) dut (
      .clk(clk), .reset(reset), .hilo_type(hilo_type), .rs_val(rs_val),
      .rt_val(rt_val), .req(req), .busy(busy), .hilo_rd(hilo_rd),
      .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Present one code for one clock edge, then return #1 after that edge with inputs idle.
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic r);
      hilo_type = op; rs_val = a; rt_val = b; req = r;
      @(posedge clk); #1;
      hilo_type = HILO_NONE; req = 1'b0;
   endtask

   // Count busy cycles (bounded), optionally driving one code during busy cycle inj_at.
   task automatic run_out(output int cnt, input int inj_at, input logic [3:0] inj_op,
                          input logic [31:0] inj_val, input logic inj_req);
      cnt = 0;
      while (busy === 1'b1 && cnt < 64) begin
         cnt++;
         if (cnt == inj_at) begin
            hilo_type = inj_op; rs_val = inj_val; req = inj_req;
         end
         @(posedge clk); #1;
         hilo_type = HILO_NONE; req = 1'b0;
      end
   endtask

   initial begin
      reset = 1'b0; hilo_type = HILO_NONE; rs_val = 32'd0; rt_val = 32'd0; req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      check("rst_rd", 64'(hilo_rd), 64'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      // signed mult -2 * 3
      issue(HILO_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
      run_out(n, 0, HILO_NONE, 32'd0, 1'b0);
      check("mult_lat", 64'(n), 64'd5);
      check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
      check("mult_lo", 64'(lo), 64'hFFFF_FFFA);

      // unsigned mult, with an mtlo attempted mid-run (must be ignored)
      issue(HILO_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
      run_out(n, 2, HILO_MTLO, 32'h0000_00CD, 1'b0);
      check("multu_lat", 64'(n), 64'd5);
      check("multu_hi", 64'(hi), 64'd1);
      check("multu_lo", 64'(lo), 64'hFFFF_FFFE);

      issue(HILO_DIVU, 32'd100, 32'd7, 1'b0);
      run_out(n, 0, HILO_NONE, 32'd0, 1'b0);
      check("divu_lat", 64'(n), 64'd10);
      check("divu_lo", 64'(lo), 64'd14);
      check("divu_hi", 64'(hi), 64'd2);

      issue(HILO_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
      run_out(n, 0, HILO_NONE, 32'd0, 1'b0);
      check("div_lat", 64'(n), 64'd10);
      check("div_lo", 64'(lo), 64'hFFFF_FFFD);
      check("div_hi", 64'(hi), 64'hFFFF_FFFF);

      // divide by zero keeps HI/LO
      issue(HILO_MTHI, 32'h11, 32'd0, 1'b0);
      check("mthi_busy", 64'(busy), 64'd0);
      check("mthi_hi", 64'(hi), 64'h11);
      issue(HILO_MTLO, 32'h22, 32'd0, 1'b0);
      check("mtlo_lo", 64'(lo), 64'h22);
      issue(HILO_DIV, 32'd9, 32'd0, 1'b0);
      run_out(n, 0, HILO_NONE, 32'd0, 1'b0);
      check("div0_lat", 64'(n), 64'd10);
      check("div0_hi", 64'(hi), 64'h11);
      check("div0_lo", 64'(lo), 64'h22);
      hilo_type = HILO_MFHI; #1;
      check("mfhi_rd", 64'(hilo_rd), 64'h11);
      hilo_type = HILO_MFLO; #1;
      check("mflo_rd", 64'(hilo_rd), 64'h22);
      hilo_type = HILO_NONE;

      // req suppresses starts and writes
      issue(HILO_MULT, 32'd5, 32'd5, 1'b1);
      check("req_busy", 64'(busy), 64'd0);
      repeat (6) @(posedge clk);
      #1;
      check("req_hi", 64'(hi), 64'h11);
      check("req_lo", 64'(lo), 64'h22);
      issue(HILO_MTLO, 32'h55, 32'd0, 1'b1);
      check("req_mtlo", 64'(lo), 64'h22);

`ifndef MD_MAC_EN
      issue(HILO_MADD, 32'd2, 32'd3, 1'b0);
      check("c9_busy", 64'(busy), 64'd0);
      check("c9_hilo", {hi, lo}, 64'h0000_0011_0000_0022);
`endif

      // req + mthi during busy cycle 3 of a divu
      issue(HILO_DIVU, 32'd100, 32'd7, 1'b0);
      run_out(n, 3, HILO_MTHI, 32'hAB, 1'b1);
      check("mid_lat", 64'(n), 64'd10);
      check("mid_hi", 64'(hi), 64'd2);
      check("mid_lo", 64'(lo), 64'd14);
      hilo_type = HILO_MFHI; #1;
      check("mid_rd", 64'(hilo_rd), 64'd2);
      hilo_type = HILO_NONE;

      // stale read while busy, then async reset in busy cycle 2
      issue(HILO_MULT, 32'd3, 32'd4, 1'b0);
      hilo_type = HILO_MFLO; #1;
      check("stale_busy", 64'(busy), 64'd1);
      check("stale_rd", 64'(hilo_rd), 64'd14);
      @(posedge clk); #2;
      reset = 1'b0; #1;
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_hi", 64'(hi), 64'd0);
      check("arst_lo", 64'(lo), 64'd0);
      @(posedge clk); #1;
      reset = 1'b1; hilo_type = HILO_NONE;
      @(posedge clk); #1;
      check("post_busy", 64'(busy), 64'd0);
      issue(HILO_MULT, 32'd6, 32'd7, 1'b0);
      run_out(n, 0, HILO_NONE, 32'd0, 1'b0);
      check("post_lat", 64'(n), 64'd5);
      check("post_hilo", {hi, lo}, 64'd42);

`ifdef MD_MAC_EN
      issue(HILO_MTHI, 32'd0, 32'd0, 1'b0);
      issue(HILO_MTLO, 32'd5, 32'd0, 1'b0);
      issue(HILO_MADD, 32'd2, 32'd3, 1'b0);
      run_out(n, 0, HILO_NONE, 32'd0, 1'b0);
      check("madd_lat", 64'(n), 64'd5);
      check("madd_hilo", {hi, lo}, 64'd11);
      issue(HILO_MSUB, 32'd2, 32'd7, 1'b0);
      run_out(n, 0, HILO_NONE, 32'd0, 1'b0);
      check("msub_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
